// File: rtl/jump_bundle_ras_pkg.sv
// Shared definitions for the bundle jump predictor: decoder jumpType codes,
// redirect kinds and the RAS checkpoint layout for the default 16-entry stack.
package jump_bundle_ras_pkg;

    localparam logic [4:0] JT_UNCOND = 5'b10000;
    localparam logic [4:0] JT_INDIR  = 5'b10001;
    localparam logic [4:0] JT_SYS    = 5'b11001;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'd0,
        KIND_DIRECT = 2'd1,
        KIND_RET    = 2'd2,
        KIND_INDIR  = 2'd3
    } kind_e;

    localparam int unsigned RAS_DEPTH = 16;
    localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned RAS_CNT_W = RAS_PTR_W + 1;

    typedef struct packed {
        logic [RAS_PTR_W-1:0] ptr;
        logic [RAS_CNT_W-1:0] cnt;
    } ras_ckpt_t;

endpackage

// File: rtl/jump_bundle_ras_ras_stack.sv
// Circular return-address stack: ptr addresses the current top entry,
// cnt saturates at DEPTH so overflow silently overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned IP_WIDTH = 48,
    parameter int unsigned PTR_W    = $clog2(DEPTH),
    parameter int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [IP_WIDTH-1:0] push_addr,
    input  logic                restore,
    input  logic [PTR_W-1:0]    restore_ptr,
    input  logic [CNT_W-1:0]    restore_cnt,
    output logic [IP_WIDTH-1:0] top,
    output logic [CNT_W-1:0]    cnt,
    output logic [PTR_W-1:0]    nxt_ptr,
    output logic [CNT_W-1:0]    nxt_cnt
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [IP_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    ptr;

    assign top = mem[ptr];

    always_comb begin
        nxt_ptr = ptr;
        nxt_cnt = cnt;
        if (restore) begin
            nxt_ptr = restore_ptr;
            nxt_cnt = (restore_cnt > FULL) ? FULL : restore_cnt;
        end else if (push) begin
            nxt_ptr = ptr + PTR_W'(1);
            nxt_cnt = (cnt == FULL) ? FULL : cnt + CNT_W'(1);
        end else if (pop && cnt != '0) begin
            nxt_ptr = ptr - PTR_W'(1);
            nxt_cnt = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else begin
            ptr <= nxt_ptr;
            cnt <= nxt_cnt;
        end
    end

    // Entry storage carries no reset; it is only meaningful below cnt.
    always_ff @(posedge clk) begin
        if (push && !restore) begin
            mem[nxt_ptr] <= push_addr;
        end
    end

endmodule

// File: rtl/jump_bundle_ras.sv
// Bundle-level jump predictor: picks the first redirecting lane, computes its
// target, applies at most one RAS operation and registers the result.
module jump_bundle_ras
    import jump_bundle_ras_pkg::*;
#(
    parameter int unsigned LANES    = 4,
    parameter int unsigned IP_WIDTH = 48,
    parameter int unsigned DEPTH    = RAS_DEPTH,
    parameter int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES-1:0]             in_slot_valid,
    input  logic [LANES-1:0]             in_isJump,
    input  logic [LANES*5-1:0]           in_jumpType,
    input  logic [LANES-1:0]             in_push,
    input  logic [LANES-1:0]             in_pop,
    input  logic [LANES*65-1:0]          in_constant,
    input  logic [LANES*IP_WIDTH-1:0]    in_ip,
    input  logic [LANES*IP_WIDTH-1:0]    in_next_ip,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_taken,
    output logic [$clog2(LANES)-1:0]     out_slot,
    output logic [1:0]                   out_kind,
    output logic [IP_WIDTH-1:0]          out_target,
    output logic                         out_ret_miss,
    output logic [$clog2(DEPTH)-1:0]     out_ras_ptr,
    output logic [CNT_W-1:0]             out_ras_cnt,
    input  logic                         flush,
    input  logic [$clog2(DEPTH)-1:0]     flush_ptr,
    input  logic [CNT_W-1:0]             flush_cnt
);

    localparam int unsigned SLOT_W = $clog2(LANES);
    localparam int unsigned PTR_W  = $clog2(DEPTH);

    logic                accept;
    logic                found;
    logic [SLOT_W-1:0]   win_slot;
    logic [4:0]          win_type;
    logic                win_push;
    logic                win_pop;
    logic [IP_WIDTH-1:0] win_const;
    logic [IP_WIDTH-1:0] win_ip;
    logic [IP_WIDTH-1:0] win_next;
    kind_e               kind;
    logic [IP_WIDTH-1:0] target;
    logic                ret_miss;
    logic                do_push;
    logic                do_pop;
    logic [IP_WIDTH-1:0] ras_top;
    logic [CNT_W-1:0]    ras_cnt;
    logic [PTR_W-1:0]    ras_nxt_ptr;
    logic [CNT_W-1:0]    ras_nxt_cnt;
    kind_e               kind_q;

    assign in_ready = ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign out_kind = kind_q;

    always_comb begin
        found     = 1'b0;
        win_slot  = '0;
        win_type  = '0;
        win_push  = 1'b0;
        win_pop   = 1'b0;
        win_const = '0;
        win_ip    = '0;
        win_next  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (!found && in_slot_valid[i] && in_isJump[i] && in_jumpType[i*5+4]) begin
                found     = 1'b1;
                win_slot  = SLOT_W'(i);
                win_type  = in_jumpType[i*5 +: 5];
                win_push  = in_push[i];
                win_pop   = in_pop[i];
                win_const = in_constant[i*65 +: IP_WIDTH];
                win_ip    = in_ip[i*IP_WIDTH +: IP_WIDTH];
                win_next  = in_next_ip[i*IP_WIDTH +: IP_WIDTH];
            end
        end
    end

    // Constant bits above the IP width never reach the target.
    generate
        if (IP_WIDTH < 65) begin : g_unused_const
            logic unused_const;
            always_comb begin
                unused_const = 1'b0;
                for (int unsigned i = 0; i < LANES; i++) begin
                    unused_const = unused_const ^ (^in_constant[i*65+IP_WIDTH +: 65-IP_WIDTH]);
                end
            end
        end
    endgenerate

    always_comb begin
        kind     = KIND_NONE;
        target   = '0;
        ret_miss = 1'b0;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        if (found) begin
            case (win_type)
                JT_SYS: begin
                    kind   = KIND_DIRECT;
                    target = win_const;
                end
                JT_UNCOND: begin
                    kind    = KIND_DIRECT;
                    target  = win_ip + win_const;
                    do_push = win_push;
                end
                JT_INDIR: begin
                    if (win_pop) begin
                        kind = KIND_RET;
                        if (ras_cnt == '0) begin
                            ret_miss = 1'b1;
                        end else begin
                            target = ras_top;
                            do_pop = 1'b1;
                        end
                    end else begin
                        kind = KIND_INDIR;
                    end
                end
                default: kind = KIND_INDIR;
            endcase
        end
    end

    ras_stack #(
        .DEPTH    (DEPTH),
        .IP_WIDTH (IP_WIDTH),
        .PTR_W    (PTR_W),
        .CNT_W    (CNT_W)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push        (accept & do_push),
        .pop         (accept & do_pop),
        .push_addr   (win_next),
        .restore     (flush),
        .restore_ptr (flush_ptr),
        .restore_cnt (flush_cnt),
        .top         (ras_top),
        .cnt         (ras_cnt),
        .nxt_ptr     (ras_nxt_ptr),
        .nxt_cnt     (ras_nxt_cnt)
    );

    // in_ready already excludes flush, so flush and accept never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_taken    <= 1'b0;
            out_slot     <= '0;
            kind_q       <= KIND_NONE;
            out_target   <= '0;
            out_ret_miss <= 1'b0;
            out_ras_ptr  <= '0;
            out_ras_cnt  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_taken    <= found;
            out_slot     <= win_slot;
            kind_q       <= kind;
            out_target   <= target;
            out_ret_miss <= ret_miss;
            out_ras_ptr  <= ras_nxt_ptr;
            out_ras_cnt  <= ras_nxt_cnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jump_bundle_ras.sv
// Scoreboard bench for jump_bundle_ras: stimulus queues hand-computed results,
// a monitor pops and compares each output transfer.
module tb_jump_bundle_ras;
    import jump_bundle_ras_pkg::*;

    localparam int LANES = 4;
    localparam int IPW   = 48;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES-1:0]     in_slot_valid;
    logic [LANES-1:0]     in_isJump;
    logic [LANES*5-1:0]   in_jumpType;
    logic [LANES-1:0]     in_push;
    logic [LANES-1:0]     in_pop;
    logic [LANES*65-1:0]  in_constant;
    logic [LANES*IPW-1:0] in_ip;
    logic [LANES*IPW-1:0] in_next_ip;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_taken;
    logic [1:0]           out_slot;
    logic [1:0]           out_kind;
    logic [IPW-1:0]       out_target;
    logic                 out_ret_miss;
    logic [3:0]           out_ras_ptr;
    logic [4:0]           out_ras_cnt;
    logic                 flush;
    logic [3:0]           flush_ptr;
    logic [4:0]           flush_cnt;

    typedef struct {
        logic           taken;
        logic [1:0]     slot;
        logic [1:0]     kind;
        logic [IPW-1:0] target;
        logic           miss;
        ras_ckpt_t      ck;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    jump_bundle_ras #(.LANES(LANES), .IP_WIDTH(IPW), .DEPTH(16), .CNT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_slot_valid (in_slot_valid),
        .in_isJump     (in_isJump),
        .in_jumpType   (in_jumpType),
        .in_push       (in_push),
        .in_pop        (in_pop),
        .in_constant   (in_constant),
        .in_ip         (in_ip),
        .in_next_ip    (in_next_ip),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_taken     (out_taken),
        .out_slot      (out_slot),
        .out_kind      (out_kind),
        .out_target    (out_target),
        .out_ret_miss  (out_ret_miss),
        .out_ras_ptr   (out_ras_ptr),
        .out_ras_cnt   (out_ras_cnt),
        .flush         (flush),
        .flush_ptr     (flush_ptr),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_lanes();
        in_slot_valid = '0;
        in_isJump     = '0;
        in_jumpType   = '0;
        in_push       = '0;
        in_pop        = '0;
        in_constant   = '0;
        in_ip         = '0;
        in_next_ip    = '0;
    endtask

    task automatic set_lane(input int l, input logic [4:0] t, input logic psh, input logic pp,
                            input logic [64:0] c, input logic [IPW-1:0] ip, input logic [IPW-1:0] nip);
        in_slot_valid[l]        = 1'b1;
        in_isJump[l]            = 1'b1;
        in_jumpType[l*5 +: 5]   = t;
        in_push[l]              = psh;
        in_pop[l]               = pp;
        in_constant[l*65 +: 65] = c;
        in_ip[l*IPW +: IPW]     = ip;
        in_next_ip[l*IPW +: IPW] = nip;
    endtask

    task automatic expect_out(input logic tk, input logic [1:0] sl, input logic [1:0] kd,
                              input logic [IPW-1:0] tg, input logic ms, input logic [3:0] p,
                              input logic [4:0] c);
        exp_t e;
        e.taken  = tk;
        e.slot   = sl;
        e.kind   = kd;
        e.target = tg;
        e.miss   = ms;
        e.ck.ptr = p;
        e.ck.cnt = c;
        sb.push_back(e);
    endtask

    // Holds in_valid until the bundle is accepted; returns at posedge+1.
    task automatic issue();
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        chk("accept_timeout", 64'(ok), 64'd1);
        if (ok) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [3:0] p, input logic [4:0] c);
        flush     = 1'b1;
        flush_ptr = p;
        flush_cnt = c;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("taken",    64'(out_taken),    64'(e.taken));
                    chk("slot",     64'(out_slot),     64'(e.slot));
                    chk("kind",     64'(out_kind),     64'(e.kind));
                    chk("target",   64'(out_target),   64'(e.target));
                    chk("ret_miss", 64'(out_ret_miss), 64'(e.miss));
                    chk("ras_ptr",  64'(out_ras_ptr),  64'(e.ck.ptr));
                    chk("ras_cnt",  64'(out_ras_cnt),  64'(e.ck.cnt));
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        flush = 1'b0; flush_ptr = '0; flush_cnt = '0;
        clear_lanes();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   64'(out_valid),    64'd0);
        chk("rst_taken",   64'(out_taken),    64'd0);
        chk("rst_kind",    64'(out_kind),     64'd0);
        chk("rst_target",  64'(out_target),   64'd0);
        chk("rst_miss",    64'(out_ret_miss), 64'd0);
        chk("rst_ras_cnt", 64'(out_ras_cnt),  64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Async reset while a result is pending discards it and the RAS state.
        @(posedge clk); #1;
        clear_lanes();
        set_lane(0, JT_UNCOND, 1'b1, 1'b0, 65'h4, 48'h0, 48'h555);
        issue();
        chk("pre_rst_valid", 64'(out_valid),   64'd1);
        chk("pre_rst_cnt",   64'(out_ras_cnt), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid),   64'd0);
        chk("async_rst_cnt",   64'(out_ras_cnt), 64'd0);
        chk("async_rst_ptr",   64'(out_ras_ptr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        // Call then return.
        clear_lanes();
        set_lane(1, JT_UNCOND, 1'b1, 1'b0, 65'h40, 48'h1000, 48'h1004);
        expect_out(1'b1, 2'd1, 2'd1, 48'h1040, 1'b0, 4'd1, 5'd1);
        issue();
        clear_lanes();
        set_lane(0, JT_INDIR, 1'b0, 1'b1, 65'h0, 48'h2000, 48'h2004);
        expect_out(1'b1, 2'd0, 2'd2, 48'h1004, 1'b0, 4'd0, 5'd0);
        issue();

        // Lane priority: conditional and invalid slots are skipped, no push from lane3.
        clear_lanes();
        set_lane(0, 5'b00101, 1'b1, 1'b0, 65'h10, 48'h100, 48'h104);
        set_lane(1, JT_UNCOND, 1'b1, 1'b0, 65'h10, 48'h200, 48'h204);
        in_slot_valid[1] = 1'b0;
        set_lane(2, JT_SYS, 1'b0, 1'b0, 65'h70fe, 48'h300, 48'h304);
        set_lane(3, JT_UNCOND, 1'b1, 1'b0, 65'h10, 48'h400, 48'h404);
        expect_out(1'b1, 2'd2, 2'd1, 48'h70fe, 1'b0, 4'd0, 5'd0);
        issue();

        // No winner.
        clear_lanes();
        set_lane(0, 5'b00101, 1'b0, 1'b0, 65'h10, 48'h100, 48'h104);
        expect_out(1'b0, 2'd0, 2'd0, 48'h0, 1'b0, 4'd0, 5'd0);
        issue();

        // Indirect without pop, and an unlisted unconditional type.
        clear_lanes();
        set_lane(3, JT_INDIR, 1'b0, 1'b0, 65'h10, 48'h100, 48'h104);
        expect_out(1'b1, 2'd3, 2'd3, 48'h0, 1'b0, 4'd0, 5'd0);
        issue();
        clear_lanes();
        set_lane(1, 5'b10100, 1'b1, 1'b1, 65'h10, 48'h100, 48'h104);
        expect_out(1'b1, 2'd1, 2'd3, 48'h0, 1'b0, 4'd0, 5'd0);
        issue();

        // Target adder wraps at IP width; constant bits above it are dropped.
        clear_lanes();
        set_lane(0, JT_UNCOND, 1'b0, 1'b0, 65'h1_0000_0000_0000_0020, 48'hFFFF_FFFF_FFF0, 48'h0);
        expect_out(1'b1, 2'd0, 2'd1, 48'h10, 1'b0, 4'd0, 5'd0);
        issue();

        // Overflow: 17 pushes, 16 good pops, then a miss.
        for (int k = 0; k < 17; k++) begin
            clear_lanes();
            set_lane(0, JT_UNCOND, 1'b1, 1'b0, 65'h8, 48'h0, 48'(32'h100 + k));
            expect_out(1'b1, 2'd0, 2'd1, 48'h8, 1'b0, 4'((k + 1) % 16), 5'((k + 1 > 16) ? 16 : k + 1));
            issue();
        end
        for (int j = 0; j < 16; j++) begin
            clear_lanes();
            set_lane(0, JT_INDIR, 1'b0, 1'b1, 65'h0, 48'h0, 48'h0);
            expect_out(1'b1, 2'd0, 2'd2, 48'(32'h110 - j), 1'b0, 4'((16 - j) % 16), 5'(15 - j));
            issue();
        end
        clear_lanes();
        set_lane(0, JT_INDIR, 1'b0, 1'b1, 65'h0, 48'h0, 48'h0);
        expect_out(1'b1, 2'd0, 2'd2, 48'h0, 1'b1, 4'd1, 5'd0);
        issue();
        wait_drain();

        // Backpressure: second bundle waits, outputs hold, one RAS update each.
        out_ready = 1'b0;
        clear_lanes();
        set_lane(0, JT_UNCOND, 1'b1, 1'b0, 65'h10, 48'h3000, 48'h2000);
        expect_out(1'b1, 2'd0, 2'd1, 48'h3010, 1'b0, 4'd2, 5'd1);
        issue();
        clear_lanes();
        set_lane(0, JT_INDIR, 1'b0, 1'b1, 65'h0, 48'h0, 48'h0);
        expect_out(1'b1, 2'd0, 2'd2, 48'h2000, 1'b0, 4'd1, 5'd0);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready),    64'd0);
            chk("stall_valid",    64'(out_valid),   64'd1);
            chk("stall_target",   64'(out_target),  64'h3010);
            chk("stall_cnt",      64'(out_ras_cnt), 64'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue();
        wait_drain();

        // Flush: restore to an earlier checkpoint while a bundle is offered.
        do_flush(4'd0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            clear_lanes();
            set_lane(0, JT_UNCOND, 1'b1, 1'b0, 65'h10, 48'h500, 48'(32'hA00 + 4 * k));
            expect_out(1'b1, 2'd0, 2'd1, 48'h510, 1'b0, 4'(k + 1), 5'(k + 1));
            issue();
        end
        clear_lanes();
        set_lane(0, JT_UNCOND, 1'b1, 1'b0, 65'h10, 48'h500, 48'hBBB0);
        flush = 1'b1; flush_ptr = 4'd1; flush_cnt = 5'd1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        clear_lanes();
        set_lane(0, JT_INDIR, 1'b0, 1'b1, 65'h0, 48'h0, 48'h0);
        expect_out(1'b1, 2'd0, 2'd2, 48'hA00, 1'b0, 4'd0, 5'd0);
        issue();
        expect_out(1'b1, 2'd0, 2'd2, 48'h0, 1'b1, 4'd0, 5'd0);
        issue();
        wait_drain();

        // Flush count above DEPTH saturates; entry 5 still holds an overflow push.
        do_flush(4'd5, 5'd20);
        clear_lanes();
        expect_out(1'b0, 2'd0, 2'd0, 48'h0, 1'b0, 4'd5, 5'd16);
        issue();
        set_lane(2, JT_INDIR, 1'b0, 1'b1, 65'h0, 48'h0, 48'h0);
        expect_out(1'b1, 2'd2, 2'd2, 48'h104, 1'b0, 4'd4, 5'd15);
        issue();
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
